// File: rtl/legv8_exec_unit_pkg.sv
// Shared constants, decoded-control record and R-format decode helper for the
// LEGv8 execute/memory slice.
package legv8_exec_unit_pkg;

    // Data memory geometry: 64 words of 32 bits, word index taken from byte address [7:2].
    localparam int MEM_DEPTH  = 64;
    localparam int MEM_ADDR_W = 6;

    // Opcodes, each sized to the instruction field it is matched against.
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_EOR  = 11'h650;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [8:0]  OP_MOVZ = 9'h1A5;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [5:0]  OP_B    = 6'h05;

    // ALU operation codes.
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_ORR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_PASS = 4'd7;
    localparam logic [3:0] ALU_EOR  = 4'd9;
    localparam logic [3:0] ALU_SUB  = 4'd10;
    localparam logic [3:0] ALU_NAND = 4'd12;
    localparam logic [3:0] ALU_MOV  = 4'd13;

    // Everything the decoder produces for one instruction; registered as a unit.
    typedef struct packed {
        logic [4:0]  readRegister1;
        logic [4:0]  readRegister2;
        logic [4:0]  writeRegister;
        logic        regWriteFlag;
        logic        memReadFlag;
        logic        memWriteFlag;
        logic        memToRegFlag;
        logic        aluSRC;
        logic        branchFlag;
        logic        unconditionalBranchFlag;
        logic [3:0]  aluControlCode;
        logic [31:0] branchOffset;
        logic [31:0] immediate;
    } decoded_t;

    // Register-to-register ops share one field layout and differ only in ALU code.
    function automatic decoded_t rFormat(input logic [31:0] instr, input logic [3:0] code);
        decoded_t d;
        d                = '0;
        d.readRegister1  = instr[9:5];
        d.readRegister2  = instr[20:16];
        d.writeRegister  = instr[4:0];
        d.regWriteFlag   = 1'b1;
        d.aluControlCode = code;
        return d;
    endfunction

endpackage

// File: rtl/legv8_exec_unit_alu.sv
// Combinational 32-bit ALU: arithmetic/logic ops, carry and zero detection.
module legv8_alu
    import legv8_exec_unit_pkg::*;
(
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [3:0]  aluControlCode,
    output logic [31:0] result,
    output logic        zeroFlag,
    output logic        carryBit
);

    logic [32:0] sum;

    assign sum = {1'b0, operandA} + {1'b0, operandB};

    // Select the operation result and the carry that goes with it.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        result   = '0;
        carryBit = 1'b0;
        case (aluControlCode)
            ALU_ADD: begin
                result   = sum[31:0];
                carryBit = sum[32];
            end
            ALU_SUB: begin
                result   = operandA - operandB;
                carryBit = (operandA >= operandB);
            end
            ALU_AND:  result = operandA & operandB;
            ALU_ORR:  result = operandA | operandB;
            ALU_EOR:  result = operandA ^ operandB;
            ALU_NOR:  result = ~(operandA | operandB);
            ALU_NAND: result = ~(operandA & operandB);
            ALU_PASS: result = operandB;
            ALU_MOV:  result = operandB;
            default:  result = '0;
        endcase
    end

    assign zeroFlag = (result == 32'd0);

endmodule

// File: rtl/legv8_exec_unit.sv
// Execute/memory slice: registered decoder, ALU, 64-word data memory and writeback mux.
module legv8_exec_unit
    import legv8_exec_unit_pkg::*;
(
    input  logic        clock,
    input  logic        resetN,
    input  logic [31:0] instruction,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    output logic [4:0]  readRegister1,
    output logic [4:0]  readRegister2,
    output logic [4:0]  writeRegister,
    output logic        regWriteFlag,
    output logic        memReadFlag,
    output logic        memWriteFlag,
    output logic        memToRegFlag,
    output logic        aluSRC,
    output logic        branchFlag,
    output logic        unconditionalBranchFlag,
    output logic [3:0]  aluControlCode,
    output logic [31:0] branchOffset,
    output logic [31:0] result,
    output logic        zeroFlag,
    output logic        carryBit,
    output logic [31:0] readData
);

    decoded_t              decNext;
    decoded_t              decReg;
    logic [31:0]           operandB;
    logic [MEM_ADDR_W-1:0] wordIndex;
    logic [31:0]           dataMem [MEM_DEPTH];

    // Decode the incoming instruction, longest opcode first.
    always_comb begin
        decNext                = '0;
        decNext.aluControlCode = ALU_ADD;
        case (instruction[31:21])
            OP_ADD: decNext = rFormat(instruction, ALU_ADD);
            OP_SUB: decNext = rFormat(instruction, ALU_SUB);
            OP_AND: decNext = rFormat(instruction, ALU_AND);
            OP_ORR: decNext = rFormat(instruction, ALU_ORR);
            OP_EOR: decNext = rFormat(instruction, ALU_EOR);
            OP_LDUR: begin
                decNext.readRegister1 = instruction[9:5];
                decNext.writeRegister = instruction[4:0];
                decNext.immediate     = {{23{instruction[20]}}, instruction[20:12]};
                decNext.aluSRC        = 1'b1;
                decNext.memReadFlag   = 1'b1;
                decNext.memToRegFlag  = 1'b1;
                decNext.regWriteFlag  = 1'b1;
            end
            OP_STUR: begin
                decNext.readRegister1 = instruction[9:5];
                decNext.readRegister2 = instruction[4:0];
                decNext.immediate     = {{23{instruction[20]}}, instruction[20:12]};
                decNext.aluSRC        = 1'b1;
                decNext.memWriteFlag  = 1'b1;
            end
            default: begin
                if (instruction[31:22] == OP_ADDI) begin
                    decNext.readRegister1 = instruction[9:5];
                    decNext.writeRegister = instruction[4:0];
                    decNext.immediate     = {20'd0, instruction[21:10]};
                    decNext.aluSRC        = 1'b1;
                    decNext.regWriteFlag  = 1'b1;
                end else if (instruction[31:23] == OP_MOVZ) begin
                    decNext.writeRegister  = instruction[4:0];
                    decNext.aluSRC         = 1'b1;
                    decNext.regWriteFlag   = 1'b1;
                    decNext.aluControlCode = ALU_MOV;
                    // Shift amounts of 32 and 48 fall off a 32-bit datapath.
                    case (instruction[22:21])
                        2'd0:    decNext.immediate = {16'd0, instruction[20:5]};
                        2'd1:    decNext.immediate = {instruction[20:5], 16'd0};
                        default: decNext.immediate = '0;
                    endcase
                end else if (instruction[31:24] == OP_CBZ) begin
                    decNext.readRegister2  = instruction[4:0];
                    decNext.branchFlag     = 1'b1;
                    decNext.aluControlCode = ALU_PASS;
                    decNext.branchOffset   = {{13{instruction[23]}}, instruction[23:5]};
                end else if (instruction[31:26] == OP_B) begin
                    decNext.unconditionalBranchFlag = 1'b1;
                    decNext.branchOffset = {{6{instruction[25]}}, instruction[25:0]};
                end
            end
        endcase
    end

    // Hold the decoded instruction for the following cycle; reset discards it.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (!resetN) decReg <= '0;
        else         decReg <= decNext;
    end

    assign readRegister1           = decReg.readRegister1;
    assign readRegister2           = decReg.readRegister2;
    assign writeRegister           = decReg.writeRegister;
    assign regWriteFlag            = decReg.regWriteFlag;
    assign memReadFlag             = decReg.memReadFlag;
    assign memWriteFlag            = decReg.memWriteFlag;
    assign memToRegFlag            = decReg.memToRegFlag;
    assign aluSRC                  = decReg.aluSRC;
    assign branchFlag              = decReg.branchFlag;
    assign unconditionalBranchFlag = decReg.unconditionalBranchFlag;
    assign aluControlCode          = decReg.aluControlCode;
    assign branchOffset            = decReg.branchOffset;

    assign operandB = decReg.aluSRC ? decReg.immediate : readData2;

    legv8_alu alu (
        .operandA       (readData1),
        .operandB       (operandB),
        .aluControlCode (decReg.aluControlCode),
        .result         (result),
        .zeroFlag       (zeroFlag),
        .carryBit       (carryBit)
    );

    // Byte address wraps modulo 256; low two bits select nothing.
    assign wordIndex = result[7:2];

    // Commit stores at the end of their decoded cycle; reset clears the array and wins over a store.
    always_ff @(posedge clock) begin
        // NOTE: the whole array must reset to zero, so it is flops, not a RAM macro.
        if (!resetN) begin
            for (int i = 0; i < MEM_DEPTH; i++) dataMem[i] <= '0;
        end else if (decReg.memWriteFlag) begin
            dataMem[wordIndex] <= readData2;
        end
    end

    assign readData = decReg.memToRegFlag ? dataMem[wordIndex] : result;

endmodule

// File: tb/tb_legv8_exec_unit.sv
// Directed self-checking bench for legv8_exec_unit.
module tb_legv8_exec_unit;

    logic        clock;
    logic        resetN;
    logic [31:0] instruction;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic [4:0]  writeRegister;
    logic        regWriteFlag;
    logic        memReadFlag;
    logic        memWriteFlag;
    logic        memToRegFlag;
    logic        aluSRC;
    logic        branchFlag;
    logic        unconditionalBranchFlag;
    logic [3:0]  aluControlCode;
    logic [31:0] branchOffset;
    logic [31:0] result;
    logic        zeroFlag;
    logic        carryBit;
    logic [31:0] readData;

    int checkCount = 0;
    int passCount  = 0;

    legv8_exec_unit dut (
        .clock                   (clock),
        .resetN                  (resetN),
        .instruction             (instruction),
        .readData1               (readData1),
        .readData2               (readData2),
        .readRegister1           (readRegister1),
        .readRegister2           (readRegister2),
        .writeRegister           (writeRegister),
        .regWriteFlag            (regWriteFlag),
        .memReadFlag             (memReadFlag),
        .memWriteFlag            (memWriteFlag),
        .memToRegFlag            (memToRegFlag),
        .aluSRC                  (aluSRC),
        .branchFlag              (branchFlag),
        .unconditionalBranchFlag (unconditionalBranchFlag),
        .aluControlCode          (aluControlCode),
        .branchOffset            (branchOffset),
        .result                  (result),
        .zeroFlag                (zeroFlag),
        .carryBit                (carryBit),
        .readData                (readData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetN      = 1'b0;
        instruction = 32'h0;
        readData1   = 32'd0;
        readData2   = 32'd0;

        // Reset state
        tick();
        check("rst_code", aluControlCode, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", zeroFlag, 32'd1);
        check("rst_carry", carryBit, 32'd0);
        check("rst_regwrite", regWriteFlag, 32'd0);

        // ADD X9, X20, X21
        resetN = 1'b1; instruction = 32'h8B150289; readData1 = 32'd15; readData2 = 32'd15;
        tick();
        check("add_reg1", readRegister1, 32'd20);
        check("add_reg2", readRegister2, 32'd21);
        check("add_write", writeRegister, 32'd9);
        check("add_regwrite", regWriteFlag, 32'd1);
        check("add_code", aluControlCode, 32'd2);
        check("add_result", result, 32'd30);
        check("add_zero", zeroFlag, 32'd0);
        check("add_readdata", readData, 32'd30);
        check("add_carry", carryBit, 32'd0);

        // SUB equal operands
        instruction = 32'hCB150289;
        tick();
        check("sub_code", aluControlCode, 32'd10);
        check("sub_result", result, 32'd0);
        check("sub_zero", zeroFlag, 32'd1);
        check("sub_carry", carryBit, 32'd1);
        // SUB with borrow, same decoded cycle
        readData1 = 32'd3; readData2 = 32'd5; #1;
        check("sub_borrow_result", result, 32'hFFFFFFFE);
        check("sub_borrow_carry", carryBit, 32'd0);

        // ADD wrap
        instruction = 32'h8B150289; readData1 = 32'hFFFFFFFF; readData2 = 32'd1;
        tick();
        check("addwrap_result", result, 32'd0);
        check("addwrap_carry", carryBit, 32'd1);
        check("addwrap_zero", zeroFlag, 32'd1);

        // Logic ops X3 = X1 op X2
        readData1 = 32'hF0F01234; readData2 = 32'h0FF000FF;
        instruction = 32'h8A020023;
        tick();
        check("and_reg1", readRegister1, 32'd1);
        check("and_reg2", readRegister2, 32'd2);
        check("and_write", writeRegister, 32'd3);
        check("and_code", aluControlCode, 32'd6);
        check("and_result", result, 32'h00F00034);
        instruction = 32'hAA020023;
        tick();
        check("orr_code", aluControlCode, 32'd4);
        check("orr_result", result, 32'hFFF012FF);
        instruction = 32'hCA020023;
        tick();
        check("eor_code", aluControlCode, 32'd9);
        check("eor_result", result, 32'hFF0012CB);

        // STUR X10, [X1, #0]
        instruction = 32'hF800002A; readData1 = 32'd8; readData2 = 32'hDEADBEEF;
        tick();
        check("stur_memwrite", memWriteFlag, 32'd1);
        check("stur_reg1", readRegister1, 32'd1);
        check("stur_reg2", readRegister2, 32'd10);
        check("stur_write", writeRegister, 32'd0);
        check("stur_alusrc", aluSRC, 32'd1);
        check("stur_regwrite", regWriteFlag, 32'd0);
        check("stur_result", result, 32'd8);

        // LDUR X9, [X10, #0] sampled at the store's commit edge
        instruction = 32'hF8400149;
        tick();
        readData2 = 32'd0; #1;
        check("ldur_write", writeRegister, 32'd9);
        check("ldur_reg1", readRegister1, 32'd10);
        check("ldur_memtoreg", memToRegFlag, 32'd1);
        check("ldur_memread", memReadFlag, 32'd1);
        check("ldur_memwrite", memWriteFlag, 32'd0);
        check("ldur_readdata", readData, 32'hDEADBEEF);
        readData1 = 32'd264; #1;
        check("ldur_wrap256", readData, 32'hDEADBEEF);
        readData1 = 32'd11; #1;
        check("ldur_lowbits", readData, 32'hDEADBEEF);
        readData1 = 32'd12; #1;
        check("ldur_other_word", readData, 32'd0);

        // CBZ X0, offset 0x4000
        instruction = 32'hB4080000; readData1 = 32'd77; readData2 = 32'd0;
        tick();
        check("cbz_branch", branchFlag, 32'd1);
        check("cbz_zero", zeroFlag, 32'd1);
        check("cbz_reg2", readRegister2, 32'd0);
        check("cbz_code", aluControlCode, 32'd7);
        check("cbz_offset", branchOffset, 32'h00004000);
        readData2 = 32'd5; #1;
        check("cbz_nonzero", zeroFlag, 32'd0);

        // B 0
        instruction = 32'h14000000;
        tick();
        check("b_uncond", unconditionalBranchFlag, 32'd1);
        check("b_branch", branchFlag, 32'd0);
        check("b_offset", branchOffset, 32'd0);
        check("b_code", aluControlCode, 32'd2);

        // MOVZ X9, #0xFF, LSL #16
        instruction = 32'hD2A01FE9;
        tick();
        check("movz_write", writeRegister, 32'd9);
        check("movz_alusrc", aluSRC, 32'd1);
        check("movz_code", aluControlCode, 32'd13);
        check("movz_result", result, 32'h00FF0000);
        check("movz_regwrite", regWriteFlag, 32'd1);

        // ADDI X22, X22, #1
        instruction = 32'h910006D6; readData1 = 32'd5;
        tick();
        check("addi_result", result, 32'd6);
        check("addi_write", writeRegister, 32'd22);
        check("addi_reg1", readRegister1, 32'd22);

        // Unrecognised opcode
        instruction = 32'h00000000;
        tick();
        check("unk_code", aluControlCode, 32'd2);
        check("unk_alusrc", aluSRC, 32'd0);
        check("unk_regwrite", regWriteFlag, 32'd0);
        check("unk_write", writeRegister, 32'd0);
        check("unk_reg1", readRegister1, 32'd0);

        // Reset lands on a store's commit edge
        instruction = 32'hF800002A; readData1 = 32'd16; readData2 = 32'h12345678;
        tick();
        check("rst_stur_memwrite", memWriteFlag, 32'd1);
        resetN = 1'b0; instruction = 32'hF8400149;
        tick();
        check("midrst_memwrite", memWriteFlag, 32'd0);
        check("midrst_code", aluControlCode, 32'd0);
        check("midrst_zero", zeroFlag, 32'd1);
        check("midrst_memtoreg", memToRegFlag, 32'd0);
        resetN = 1'b1;
        tick();
        check("postrst_memtoreg", memToRegFlag, 32'd1);
        check("postrst_word4", readData, 32'd0);
        readData1 = 32'd8; #1;
        check("postrst_word2", readData, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/legv8_exec_unit.md
# legv8_exec_unit

Execute/memory slice of the single-cycle LEGv8-subset processor, 32-bit datapath. It combines three parts: a registered instruction decoder, a combinational ALU and a 64-word data memory with writeback mux. It takes the fetched instruction and the two register-file read values from operand prep. It returns register IDs, control flags, branch offset, ALU flags and the writeback value to operand prep and the PC.

## Interface
- No parameters; memory depth fixed at 64 words × 32 bits.
- clock  in  1  single processor clock, rising edge.
- resetN  in  1  reset, synchronous and active-low.
- instruction  in  32  current instruction.
- readData1  in  32  value of readRegister1 (ALU operand A).
- readData2  in  32  value of readRegister2 (ALU operand B when aluSRC=0; store data).
- readRegister1, readRegister2, writeRegister  out  5 each  decoded register IDs.
- regWriteFlag, memReadFlag, memWriteFlag, memToRegFlag, aluSRC, branchFlag, unconditionalBranchFlag  out  1 each  decoded control.
- aluControlCode  out  4  ALU operation.
- branchOffset  out  32  sign-extended word offset for PC.
- result  out  32  ALU result / memory byte address.
- zeroFlag  out  1  result == 0.
- carryBit  out  1  ALU carry.
- readData  out  32  writeback value.

## Operation
- Decode opcode by longest match:
  - 0x458 ADD, 0x658 SUB, 0x450 AND, 0x550 ORR, 0x650 EOR: R-format on bits [31:21].
  - 0x244 ADDI on bits [31:22].
  - 0x7C2 LDUR, 0x7C0 STUR on bits [31:21].
  - 0xB4 CBZ on bits [31:24].
  - 0x05 B on bits [31:26].
  - 0x1A5 MOVZ on bits [31:23].
- Field positions: Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16].
- R-format (ADD, SUB, AND, ORR, EOR):
  - reg1=Rn, reg2=Rm, write=Rd, regWrite=1, aluSRC=0.
  - Codes: ADD 2, SUB 10, AND 6, ORR 4, EOR 9.
- ADDI: reg1=Rn, write=Rd, imm = zero-extended [21:10], aluSRC=1, code 2, regWrite=1.
- LDUR: reg1=Rn, write=Rt, imm = sign-extended [20:12], aluSRC=1, code 2, memRead=1, memToReg=1, regWrite=1.
- STUR: reg1=Rn, reg2=Rt, same imm as LDUR, aluSRC=1, code 2, memWrite=1.
- CBZ: reg2=Rt, code 7, branchFlag=1, branchOffset = sign-extended [23:5].
- B: unconditionalBranchFlag=1, branchOffset = sign-extended [25:0], code 2.
- MOVZ:
  - write=Rd, aluSRC=1, code 13, regWrite=1.
  - imm = [20:5] << 16·hw, with hw=[22:21]; hw≥2 gives 0.
- Unrecognised opcode: all flags 0, all register IDs 0, code 2, branchOffset 0.
- Unused register-ID outputs are 0.
- ALU operand B = aluSRC ? imm : readData2.
- ALU codes (A=readData1):
  - 2: A+B.
  - 10: A−B.
  - 6: A&B.
  - 4: A|B.
  - 9: A^B.
  - 5: ~(A|B).
  - 12: ~(A&B).
  - 7: B (CBZ test).
  - 13: B (MOV).
  - Any other code: result 0.
- carryBit:
  - ADD: bit 32 of the 33-bit sum.
  - SUB: 1 when A ≥ B unsigned (no borrow).
  - All other codes: 0.
- zeroFlag = (result == 0) for every code.
- Memory addressing: word index = result[7:2]. Bits [1:0] and [31:8] are ignored, so addresses wrap modulo 256 bytes.
- Memory write: on the rising edge with memWriteFlag=1, mem[index] ← readData2.
- Memory read and writeback: combinational. readData = memToRegFlag ? mem[index] : result.

## Timing
- Decoder outputs are registered. The instruction sampled at rising edge N drives all decoded outputs and the immediate during cycle N+1. Latency is 1 cycle.
- result, zeroFlag, carryBit and readData are combinational from the registered control and the current readData1/readData2.
- A store commits at the edge that ends its decoded cycle.
- A load in the same cycle as that store's edge sees the new data in the following cycle.
- Reset: at a rising edge with resetN=0:
  - All decoded outputs → 0, so aluControlCode=0, result=0, zeroFlag=1, carryBit=0.
  - All 64 memory words → 0.
  - Reset overrides a pending write.
- Reset mid-sequence discards the in-flight decoded instruction.
- The first instruction after reset release is sampled at the first edge with resetN=1.

## Structure
- Shared package holds:
  - Opcode constants.
  - ALU code constants (2, 4, 5, 6, 7, 9, 10, 12, 13).
  - Memory depth constant (64).
- Natural sub-module: legv8_alu, purely combinational: A, B, code → result, zeroFlag, carryBit.
- Decoder, immediate generation and memory stay in the top body.

## Test plan
- ADD 0x8B150289, readData1=15, readData2=15:
  - After one edge: reg1=20, reg2=21, write=9, regWrite=1, code 2.
  - result=30, zeroFlag=0, readData=30.
- SUB 0xCB150289 with A=B=15 → result 0, zeroFlag=1, carryBit=1. ADD with 0xFFFFFFFF+1 → result 0, carryBit=1.
- STUR 0xF800002A, readData1=8, readData2=0xDEADBEEF → word 2 written. Then LDUR 0xF8400149 with readData1=8 → write=9, memToReg=1, readData=0xDEADBEEF.
- CBZ 0xB4080000, readData2=0 → branchFlag=1, zeroFlag=1, reg2=0, branchOffset=0x00004000. B 0x14000000 → unconditionalBranchFlag=1, branchOffset=0.
- MOVZ 0xD2A01FE9 → write=9, aluSRC=1, code 13, result=0x00FF0000. ADDI 0x910006D6 with readData1=5 → result 6, write=22.
- Reset mid-operation:
  - resetN=0 for one edge during a store → memory word unchanged (0), all flags 0, zeroFlag=1.
  - After release, a read of any address returns 0.
